axi_arbiter_n: RTL and testbench

Parametrised N-master to 1-slave AXI4 arbiter that lets several masters share one downstream AXI port (e.g. IFU, LSU and a DMA engine sharing one memory/peripheral bus). Read and write paths are arbitrated independently with round-robin fairness. Each path holds one transaction at a time, locked from address handshake through last data beat (read) or write response (write). The write path regenerates WLAST from a captured AWLEN beat counter and flags masters whose WLAST disagrees.

---
 rtl/axi_arbiter_n.sv | 263 ++++++++++++++++++++++++++
 tb/tb_axi_arbiter_n.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_arbiter_n.sv
// axi_arbiter_n: N-master to 1-slave AXI4 arbiter. Read and write paths have
// independent round-robin arbiters; each path carries one transaction at a
// time. The write path regenerates WLAST from the captured AWLEN and flags
// masters whose own WLAST disagrees.
module axi_arbiter_n #(
  parameter int NUM_MST = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  // read address, upstream
  input  logic [NUM_MST-1:0]                   s_arvalid,
  input  logic [NUM_MST-1:0][ADDR_W-1:0]       s_araddr,
  input  logic [NUM_MST-1:0][ID_W-1:0]         s_arid,
  input  logic [NUM_MST-1:0][7:0]              s_arlen,
  input  logic [NUM_MST-1:0][2:0]              s_arsize,
  input  logic [NUM_MST-1:0][1:0]              s_arburst,
  output logic [NUM_MST-1:0]                   s_arready,
  // read data, upstream
  input  logic [NUM_MST-1:0]                   s_rready,
  output logic [NUM_MST-1:0]                   s_rvalid,
  output logic [NUM_MST-1:0][1:0]              s_rresp,
  output logic [NUM_MST-1:0][DATA_W-1:0]       s_rdata,
  output logic [NUM_MST-1:0]                   s_rlast,
  output logic [NUM_MST-1:0][ID_W-1:0]         s_rid,
  // write address, upstream
  input  logic [NUM_MST-1:0]                   s_awvalid,
  input  logic [NUM_MST-1:0][ADDR_W-1:0]       s_awaddr,
  input  logic [NUM_MST-1:0][ID_W-1:0]         s_awid,
  input  logic [NUM_MST-1:0][7:0]              s_awlen,
  input  logic [NUM_MST-1:0][2:0]              s_awsize,
  input  logic [NUM_MST-1:0][1:0]              s_awburst,
  output logic [NUM_MST-1:0]                   s_awready,
  // write data, upstream
  input  logic [NUM_MST-1:0]                   s_wvalid,
  input  logic [NUM_MST-1:0][DATA_W-1:0]       s_wdata,
  input  logic [NUM_MST-1:0][DATA_W/8-1:0]     s_wstrb,
  input  logic [NUM_MST-1:0]                   s_wlast,
  output logic [NUM_MST-1:0]                   s_wready,
  // write response, upstream
  input  logic [NUM_MST-1:0]                   s_bready,
  output logic [NUM_MST-1:0]                   s_bvalid,
  output logic [NUM_MST-1:0][1:0]              s_bresp,
  output logic [NUM_MST-1:0][ID_W-1:0]         s_bid,
  // downstream port
  output logic                                 m_arvalid,
  input  logic                                 m_arready,
  output logic [ADDR_W-1:0]                    m_araddr,
  output logic [ID_W-1:0]                      m_arid,
  output logic [7:0]                           m_arlen,
  output logic [2:0]                           m_arsize,
  output logic [1:0]                           m_arburst,
  input  logic                                 m_rvalid,
  output logic                                 m_rready,
  input  logic [1:0]                           m_rresp,
  input  logic [DATA_W-1:0]                    m_rdata,
  input  logic                                 m_rlast,
  input  logic [ID_W-1:0]                      m_rid,
  output logic                                 m_awvalid,
  input  logic                                 m_awready,
  output logic [ADDR_W-1:0]                    m_awaddr,
  output logic [ID_W-1:0]                      m_awid,
  output logic [7:0]                           m_awlen,
  output logic [2:0]                           m_awsize,
  output logic [1:0]                           m_awburst,
  output logic                                 m_wvalid,
  input  logic                                 m_wready,
  output logic [DATA_W-1:0]                    m_wdata,
  output logic [DATA_W/8-1:0]                  m_wstrb,
  output logic                                 m_wlast,
  input  logic                                 m_bvalid,
  output logic                                 m_bready,
  input  logic [1:0]                           m_bresp,
  input  logic [ID_W-1:0]                      m_bid,
  // sticky per-master WLAST mismatch flags
  output logic [NUM_MST-1:0]                   wlast_err
);

  localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t          r_rd_state, w_rd_state_nxt;
  wr_state_t          r_wr_state, w_wr_state_nxt;
  logic [IDX_W-1:0]   r_rgnt, w_rgnt_nxt, r_rr_rd, w_rr_rd_nxt;
  logic [IDX_W-1:0]   r_wgnt, w_wgnt_nxt, r_rr_wr, w_rr_wr_nxt;
  logic [7:0]         r_wcnt, w_wcnt_nxt;
  logic [NUM_MST-1:0] r_wlast_err, w_wlast_err_nxt;
  logic               w_last_beat;

  // First requester strictly after the pointer, wrapping modulo NUM_MST.
  function automatic logic [IDX_W-1:0] f_rr_pick(input logic [NUM_MST-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    f_rr_pick = ptr;
    found     = 1'b0;
    for (int k = 1; k <= NUM_MST; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_MST);
      if (!found && req[idx]) begin
        f_rr_pick = idx;
        found     = 1'b1;
      end
    end
  endfunction

  assign w_last_beat = (r_wcnt == 8'd0);
  assign wlast_err   = r_wlast_err;

  // Read path state, grant and round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_state <= R_IDLE;
      r_rgnt     <= '0;
      r_rr_rd    <= IDX_W'(NUM_MST - 1);
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rgnt     <= w_rgnt_nxt;
      r_rr_rd    <= w_rr_rd_nxt;
    end
  end

  // Read next-state and combinational AR/R routing for the granted master.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rgnt_nxt     = r_rgnt;
    w_rr_rd_nxt    = r_rr_rd;
    s_arready      = '0;
    s_rvalid       = '0;
    s_rresp        = '0;
    s_rdata        = '0;
    s_rlast        = '0;
    s_rid          = '0;
    m_arvalid      = 1'b0;
    m_araddr       = '0;
    m_arid         = '0;
    m_arlen        = '0;
    m_arsize       = '0;
    m_arburst      = '0;
    m_rready       = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (|s_arvalid) begin
          w_rgnt_nxt     = f_rr_pick(s_arvalid, r_rr_rd);
          w_rd_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arvalid         = s_arvalid[r_rgnt];
        m_araddr          = s_araddr[r_rgnt];
        m_arid            = s_arid[r_rgnt];
        m_arlen           = s_arlen[r_rgnt];
        m_arsize          = s_arsize[r_rgnt];
        m_arburst         = s_arburst[r_rgnt];
        s_arready[r_rgnt] = m_arready;
        if (m_arvalid && m_arready) w_rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        s_rvalid[r_rgnt] = m_rvalid;
        s_rresp[r_rgnt]  = m_rresp;
        s_rdata[r_rgnt]  = m_rdata;
        s_rlast[r_rgnt]  = m_rlast;
        s_rid[r_rgnt]    = m_rid;
        m_rready         = s_rready[r_rgnt];
        if (m_rvalid && m_rready && m_rlast) begin
          w_rr_rd_nxt    = r_rgnt;
          w_rd_state_nxt = R_IDLE;
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // Write path state, grant, pointer, beat counter and sticky error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_state  <= W_IDLE;
      r_wgnt      <= '0;
      r_rr_wr     <= IDX_W'(NUM_MST - 1);
      r_wcnt      <= '0;
      r_wlast_err <= '0;
    end else begin
      r_wr_state  <= w_wr_state_nxt;
      r_wgnt      <= w_wgnt_nxt;
      r_rr_wr     <= w_rr_wr_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_wlast_err <= w_wlast_err_nxt;
    end
  end

  // Write next-state and AW/W/B routing; WLAST comes from the beat counter.
  always_comb begin
    w_wr_state_nxt  = r_wr_state;
    w_wgnt_nxt      = r_wgnt;
    w_rr_wr_nxt     = r_rr_wr;
    w_wcnt_nxt      = r_wcnt;
    w_wlast_err_nxt = r_wlast_err;
    s_awready       = '0;
    s_wready        = '0;
    s_bvalid        = '0;
    s_bresp         = '0;
    s_bid           = '0;
    m_awvalid       = 1'b0;
    m_awaddr        = '0;
    m_awid          = '0;
    m_awlen         = '0;
    m_awsize        = '0;
    m_awburst       = '0;
    m_wvalid        = 1'b0;
    m_wdata         = '0;
    m_wstrb         = '0;
    m_wlast         = 1'b0;
    m_bready        = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (|s_awvalid) begin
          w_wgnt_nxt     = f_rr_pick(s_awvalid, r_rr_wr);
          w_wr_state_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        m_awvalid         = s_awvalid[r_wgnt];
        m_awaddr          = s_awaddr[r_wgnt];
        m_awid            = s_awid[r_wgnt];
        m_awlen           = s_awlen[r_wgnt];
        m_awsize          = s_awsize[r_wgnt];
        m_awburst         = s_awburst[r_wgnt];
        s_awready[r_wgnt] = m_awready;
        if (m_awvalid && m_awready) begin
          w_wcnt_nxt     = s_awlen[r_wgnt];
          w_wr_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        m_wvalid         = s_wvalid[r_wgnt];
        m_wdata          = s_wdata[r_wgnt];
        m_wstrb          = s_wstrb[r_wgnt];
        m_wlast          = w_last_beat;
        s_wready[r_wgnt] = m_wready;
        if (m_wvalid && m_wready) begin
          if (s_wlast[r_wgnt] != w_last_beat) w_wlast_err_nxt[r_wgnt] = 1'b1;
          if (w_last_beat) w_wr_state_nxt = W_RESP;
          else             w_wcnt_nxt     = r_wcnt - 8'd1;
        end
      end
      W_RESP: begin
        s_bvalid[r_wgnt] = m_bvalid;
        s_bresp[r_wgnt]  = m_bresp;
        s_bid[r_wgnt]    = m_bid;
        m_bready         = s_bready[r_wgnt];
        if (m_bvalid && m_bready) begin
          w_rr_wr_nxt    = r_wgnt;
          w_wr_state_nxt = W_IDLE;
        end
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_arbiter_n.sv
// Scoreboard bench for axi_arbiter_n with three masters and a behavioural
// downstream slave. Stimulus pushes expected AR/R/AW/W/B items; a monitor
// pops and compares whenever a handshake appears.
module tb_axi_arbiter_n;
  localparam int N = 3, AW = 32, DW = 32, IW = 4, SW = DW / 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0]          s_arvalid, s_arready, s_rready, s_rvalid, s_rlast;
  logic [N-1:0][AW-1:0]  s_araddr, s_awaddr;
  logic [N-1:0][IW-1:0]  s_arid, s_rid, s_awid, s_bid;
  logic [N-1:0][7:0]     s_arlen, s_awlen;
  logic [N-1:0][2:0]     s_arsize, s_awsize;
  logic [N-1:0][1:0]     s_arburst, s_awburst, s_rresp, s_bresp;
  logic [N-1:0][DW-1:0]  s_rdata, s_wdata;
  logic [N-1:0]          s_awvalid, s_awready, s_wvalid, s_wlast, s_wready;
  logic [N-1:0][SW-1:0]  s_wstrb;
  logic [N-1:0]          s_bready, s_bvalid, wlast_err;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [AW-1:0] m_araddr, m_awaddr;
  logic [IW-1:0] m_arid, m_rid, m_awid, m_bid;
  logic [7:0]    m_arlen, m_awlen;
  logic [2:0]    m_arsize, m_awsize;
  logic [1:0]    m_arburst, m_awburst, m_rresp, m_bresp;
  logic [DW-1:0] m_rdata, m_wdata;
  logic [SW-1:0] m_wstrb;

  axi_arbiter_n #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clock(clock), .reset(reset),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rready(s_rready), .s_rvalid(s_rvalid), .s_rresp(s_rresp), .s_rdata(s_rdata),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wready(s_wready), .s_bready(s_bready), .s_bvalid(s_bvalid), .s_bresp(s_bresp),
    .s_bid(s_bid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rresp(m_rresp), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_bid(m_bid), .wlast_err(wlast_err)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] q_ar[$], q_r[$], q_aw[$], q_w[$], q_b[$];
  logic wr_toggle = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=no_event required=event", name);
  endtask

  function automatic logic [31:0] wd(input int m, input int b);
    return 32'hC0DE_0000 | 32'(m << 8) | 32'(b);
  endfunction

  task automatic push_rd(input int m, input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len);
    logic [2:0] oh;
    oh = 3'b001 << m;
    q_ar.push_back({17'b0, oh, addr, id, len});
    for (int b = 0; b <= int'(len); b++)
      q_r.push_back({4'(m), 20'b0, oh, 24'h0, addr[7:0] + 8'(b), (b == int'(len)), id});
  endtask

  // Monitor: every handshake pops one expected item and compares.
  initial begin
    logic [63:0] e;
    int m;
    forever begin
      @(negedge clock);
      if (m_arvalid && m_arready) begin
        if (q_ar.size() == 0) flag("ar_unexpected");
        else begin
          e = q_ar.pop_front();
          chk("ar", 64'({s_arready, m_araddr, m_arid, m_arlen}), 64'(e[46:0]));
        end
      end
      if (|(s_rvalid & s_rready)) begin
        if (q_r.size() == 0) flag("r_unexpected");
        else begin
          e = q_r.pop_front();
          m = int'(e[63:60]);
          chk("r", 64'({s_rvalid, s_rdata[m], s_rlast[m], s_rid[m]}), 64'(e[39:0]));
        end
      end
      if (m_awvalid && m_awready) begin
        if (q_aw.size() == 0) flag("aw_unexpected");
        else begin
          e = q_aw.pop_front();
          chk("aw", 64'({s_awready, m_awaddr, m_awid, m_awlen}), 64'(e[46:0]));
        end
      end
      if (m_wvalid && m_wready) begin
        if (q_w.size() == 0) flag("w_unexpected");
        else begin
          e = q_w.pop_front();
          chk("w", 64'({m_wdata, m_wstrb, m_wlast}), 64'(e[36:0]));
        end
      end
      if (|(s_bvalid & s_bready)) begin
        if (q_b.size() == 0) flag("b_unexpected");
        else begin
          e = q_b.pop_front();
          m = int'(e[63:60]);
          chk("b", 64'({s_bvalid, s_bid[m], s_bresp[m]}), 64'(e[8:0]));
        end
      end
    end
  end

  // Downstream slave: read data = addr[7:0]+beat; write wready optionally toggles.
  initial begin
    logic ar_hs, r_hs, r_last_hs, aw_hs, w_last_hs, b_hs;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len, rd_beat;
    logic [3:0]  rd_id, wr_id;
    logic        rd_busy;
    int          wr_st;
    rd_addr = '0; rd_len = '0; rd_beat = '0; rd_id = '0; wr_id = '0; rd_busy = 1'b0; wr_st = 0;
    m_arready = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0; m_rlast = 0; m_rid = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_bid = 0;
    forever begin
      @(negedge clock);
      ar_hs = m_arvalid && m_arready;
      r_hs = m_rvalid && m_rready;
      r_last_hs = r_hs && m_rlast;
      aw_hs = m_awvalid && m_awready;
      w_last_hs = m_wvalid && m_wready && m_wlast;
      b_hs = m_bvalid && m_bready;
      if (ar_hs) begin rd_addr = m_araddr; rd_len = m_arlen; rd_id = m_arid; end
      if (aw_hs) wr_id = m_awid;
      @(posedge clock); #1;
      if (!reset) begin
        rd_busy = 1'b0; wr_st = 0; rd_beat = '0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rlast = 0; m_rid = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bid = 0;
      end else begin
        if (ar_hs) begin
          rd_busy = 1'b1; rd_beat = '0; m_arready = 0; m_rvalid = 1;
        end else if (r_hs) begin
          if (r_last_hs) begin rd_busy = 1'b0; m_rvalid = 0; m_arready = 1; end
          else rd_beat = rd_beat + 8'd1;
        end else if (!rd_busy) m_arready = 1;
        m_rdata = {24'h0, rd_addr[7:0] + rd_beat};
        m_rlast = (rd_beat == rd_len);
        m_rid   = rd_id;
        case (wr_st)
          0: if (aw_hs) begin wr_st = 1; m_awready = 0; m_wready = 1; end
             else m_awready = 1;
          1: if (w_last_hs) begin wr_st = 2; m_wready = 0; m_bvalid = 1; m_bid = wr_id; end
             else if (wr_toggle) m_wready = !m_wready;
          default: if (b_hs) begin wr_st = 0; m_bvalid = 0; m_awready = 1; end
        endcase
      end
    end
  end

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while ((q_ar.size() + q_r.size() + q_aw.size() + q_w.size() + q_b.size()) != 0 && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    chk({name, "_pending"}, 64'(q_ar.size() + q_r.size() + q_aw.size() + q_w.size() + q_b.size()), 64'd0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic rd_txn(input int m, input logic [31:0] addr, input logic [3:0] id,
                        input logic [7:0] len);
    int cyc;
    push_rd(m, addr, id, len);
    s_araddr[m] = addr; s_arid[m] = id; s_arlen[m] = len;
    s_arsize[m] = 3'd2; s_arburst[m] = 2'b01; s_arvalid[m] = 1'b1;
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (!s_arready[m] && cyc < 100);
    if (!s_arready[m]) flag("rd_arready_timeout");
    @(posedge clock); #1;
    s_arvalid[m] = 1'b0;
  endtask

  // Holds ARVALID on every masked master until n address handshakes occur.
  task automatic rd_hold(input logic [N-1:0] mask, input int n);
    int seen, cyc;
    seen = 0; cyc = 0;
    for (int i = 0; i < N; i++) begin
      s_araddr[i] = 32'(16 * (i + 1)); s_arid[i] = 4'(i); s_arlen[i] = 8'd0;
      s_arsize[i] = 3'd2; s_arburst[i] = 2'b01;
    end
    s_arvalid = mask;
    while (seen < n && cyc < 300) begin
      @(negedge clock);
      if (m_arvalid && m_arready) seen++;
      cyc++;
    end
    if (seen < n) flag("rd_hold_timeout");
    @(posedge clock); #1;
    s_arvalid = '0;
  endtask

  task automatic wr_txn(input int m, input logic [31:0] addr, input logic [3:0] id,
                        input logic [7:0] len, input int wl_beat);
    logic [2:0] oh;
    int cyc;
    oh = 3'b001 << m;
    q_aw.push_back({17'b0, oh, addr, id, len});
    for (int b = 0; b <= int'(len); b++)
      q_w.push_back({27'b0, wd(m, b), 4'(b + 1), (b == int'(len))});
    q_b.push_back({4'(m), 51'b0, oh, id, 2'b00});
    s_awaddr[m] = addr; s_awid[m] = id; s_awlen[m] = len;
    s_awsize[m] = 3'd2; s_awburst[m] = 2'b01; s_awvalid[m] = 1'b1;
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (!s_awready[m] && cyc < 100);
    if (!s_awready[m]) flag("wr_awready_timeout");
    @(posedge clock); #1;
    s_awvalid[m] = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_wdata[m] = wd(m, b); s_wstrb[m] = 4'(b + 1);
      s_wlast[m] = (b == wl_beat); s_wvalid[m] = 1'b1;
      cyc = 0;
      do begin @(negedge clock); cyc++; end while (!s_wready[m] && cyc < 100);
      if (!s_wready[m]) flag("wr_wready_timeout");
      @(posedge clock); #1;
    end
    s_wvalid[m] = 1'b0; s_wlast[m] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    s_arvalid = '0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_awvalid = '0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0;
    s_rready = '1; s_bready = '1;
    reset = 1'b0;

    // Reset state: every handshake output and data output low.
    repeat (3) @(negedge clock);
    chk("rst_handshake", 64'({s_arready, s_rvalid, s_awready, s_wready, s_bvalid,
                              m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 64'd0);
    chk("rst_data", 64'({m_araddr, m_awaddr}), 64'd0);
    chk("rst_wlast_err", 64'(wlast_err), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock); #1;

    // Three masters request continuously: grants rotate 0,1,2,0,1,2.
    push_rd(0, 32'h10, 4'd0, 8'd0); push_rd(1, 32'h20, 4'd1, 8'd0); push_rd(2, 32'h30, 4'd2, 8'd0);
    push_rd(0, 32'h10, 4'd0, 8'd0); push_rd(1, 32'h20, 4'd1, 8'd0); push_rd(2, 32'h30, 4'd2, 8'd0);
    rd_hold(3'b111, 6);
    drain("rr3");

    // Single 4-beat read from master 1, one-cycle arbitration latency.
    push_rd(1, 32'h0000_10A0, 4'd1, 8'd3);
    s_araddr[1] = 32'h0000_10A0; s_arid[1] = 4'd1; s_arlen[1] = 8'd3;
    s_arsize[1] = 3'd2; s_arburst[1] = 2'b01; s_arvalid[1] = 1'b1;
    @(negedge clock);
    chk("lat_before_grant", 64'(m_arvalid), 64'd0);
    @(negedge clock);
    chk("lat_after_grant", 64'(m_arvalid), 64'd1);
    @(posedge clock); #1;
    s_arvalid[1] = 1'b0;
    drain("rd1");

    // Concurrent read (master 0) and write (master 1).
    fork
      rd_txn(0, 32'h40, 4'd0, 8'd1);
      wr_txn(1, 32'h1000, 4'd5, 8'd1, 1);
    join
    drain("concurrent");
    chk("err_clean", 64'(wlast_err), 64'd0);

    // Early WLAST on beat 1 of a 3-beat write from master 2.
    wr_txn(2, 32'h3000, 4'd3, 8'd2, 1);
    drain("early_wlast");
    chk("err_set", 64'(wlast_err), 64'(3'b100));

    // 8-beat write with toggling WREADY; error flag remains sticky.
    wr_toggle = 1'b1;
    wr_txn(0, 32'h2000, 4'hA, 8'd7, 7);
    drain("burst8");
    wr_toggle = 1'b0;
    chk("err_sticky", 64'(wlast_err), 64'(3'b100));

    // Reset asserted while beat 2 of a 4-beat read is on the bus.
    rd_txn(1, 32'h50, 4'd1, 8'd3);
    begin
      int cyc;
      cyc = 0;
      do begin @(negedge clock); cyc++; end while (!(s_rvalid[1] && m_rdata == 32'h51) && cyc < 100);
      if (!(s_rvalid[1] && m_rdata == 32'h51)) flag("mid_beat2_timeout");
    end
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_handshake", 64'({s_arready, s_rvalid, s_awready, s_wready, s_bvalid,
                                  m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 64'd0);
    chk("mid_rst_rdata", 64'(s_rdata[1]), 64'd0);
    chk("mid_rst_wlast_err", 64'(wlast_err), 64'd0);
    q_r.delete();
    repeat (2) @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // After reset, master 0 beats master 1 on simultaneous requests.
    push_rd(0, 32'h10, 4'd0, 8'd0);
    push_rd(1, 32'h20, 4'd1, 8'd0);
    rd_hold(3'b011, 2);
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
